// File: rtl/alu_exec_seq_if.sv
// ---------------------------------------------------------------------------
// alu_exec_seq_if
//   Bundles the instruction handshake and the register-file ports of the
//   sequenced execute stage.
//
//   Instruction side : instr_valid, instr_ready, op, rd, rs1, rs2
//   Regfile read     : readAddr1/2 (to regfile), readData1/2 (from regfile)
//   Regfile write    : writeAddr, writeIn, we
//   Status           : done, illegal (one-cycle pulses), flags {N,Z,C,V}
//
//   Modports:
//     slave  - the execute stage itself (alu_exec_seq)
//     master - the environment: instruction source plus register file
// ---------------------------------------------------------------------------
interface alu_exec_seq_if #(
    parameter int WIDTH = 12,
    parameter int AW    = 3
);
    logic             instr_valid;
    logic             instr_ready;
    logic [3:0]       op;
    logic [AW-1:0]    rd;
    logic [AW-1:0]    rs1;
    logic [AW-1:0]    rs2;
    logic [AW-1:0]    readAddr1;
    logic [AW-1:0]    readAddr2;
    logic [WIDTH-1:0] readData1;
    logic [WIDTH-1:0] readData2;
    logic [AW-1:0]    writeAddr;
    logic [WIDTH-1:0] writeIn;
    logic             we;
    logic             done;
    logic [3:0]       flags;
    logic             illegal;

    modport slave (
        input  instr_valid, op, rd, rs1, rs2, readData1, readData2,
        output instr_ready, readAddr1, readAddr2, writeAddr, writeIn,
               we, done, flags, illegal
    );

    modport master (
        output instr_valid, op, rd, rs1, rs2, readData1, readData2,
        input  instr_ready, readAddr1, readAddr2, writeAddr, writeIn,
               we, done, flags, illegal
    );
endinterface

// File: rtl/alu_exec_seq.sv
// ---------------------------------------------------------------------------
// alu_exec_seq
//   Sequenced execute stage in front of an 8 x 12-bit 2R/1W register file.
//   One instruction at a time: accept (IDLE) -> READ -> EXEC -> WB, or with
//   the multiplier built, READ -> 12 x MUL -> WB for opcode 10.
//   All outputs are registered; we/done/illegal are one-cycle pulses in WB.
//
//   Ports:
//     clk   - clock, all state on the rising edge
//     rst_n - asynchronous active-low reset (aborts any operation, no write)
//     bus   - alu_exec_seq_if.slave (handshake, regfile ports, status)
//
//   Build option:
//     ALU_EXEC_MUL_EN - when defined, opcode 10 is a 12-cycle unsigned
//                       shift-add multiply; when undefined opcode 10 is
//                       illegal and no multiplier hardware exists.
// ---------------------------------------------------------------------------
module alu_exec_seq #(
    parameter int WIDTH = 12,
    parameter int AW    = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_exec_seq_if.slave  bus
);
    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_SRA = 4'd8;
    localparam logic [3:0] OP_MOV = 4'd9;
`ifdef ALU_EXEC_MUL_EN
    localparam logic [3:0] OP_MUL = 4'd10;
    localparam int         CW     = $clog2(WIDTH);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
`ifdef ALU_EXEC_MUL_EN
        S_MUL,
`endif
        S_WB
    } state_t;

    state_t           state;
    logic [3:0]       op_q;
    logic [AW-1:0]    rd_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    // ------------------------------------------------------------------
    // Single-cycle ALU on the captured operands.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic             alu_legal;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;

    // NOTE: every variable gets a default at the top of the always_comb so
    // no path can leave it unassigned, which would infer a latch.
    always_comb begin
        alu_res   = '0;
        alu_c     = 1'b0;
        alu_v     = 1'b0;
        alu_legal = 1'b1;
        // NOTE: blocking assignments here: alu_res is written and then read
        // again (for V) within the same evaluation.
        sum_ext   = {1'b0, a_q} + {1'b0, b_q};
        // The extra top bit of the zero-extended difference is the borrow.
        diff_ext  = {1'b0, a_q} - {1'b0, b_q};
        case (op_q)
            OP_ADD: begin
                alu_res = sum_ext[MSB:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (a_q[MSB] == b_q[MSB]) && (alu_res[MSB] != a_q[MSB]);
            end
            OP_SUB: begin
                alu_res = diff_ext[MSB:0];
                alu_c   = diff_ext[WIDTH];
                alu_v   = (a_q[MSB] != b_q[MSB]) && (alu_res[MSB] != a_q[MSB]);
            end
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_XOR: alu_res = a_q ^ b_q;
            OP_NOT: alu_res = ~a_q;
            OP_SHL: begin
                alu_res = {a_q[MSB-1:0], 1'b0};
                alu_c   = a_q[MSB];
            end
            OP_SHR: begin
                alu_res = {1'b0, a_q[MSB:1]};
                alu_c   = a_q[0];
            end
            OP_SRA: begin
                alu_res = {a_q[MSB], a_q[MSB:1]};
                alu_c   = a_q[0];
            end
            OP_MOV: alu_res = a_q;
            default: alu_legal = 1'b0;
        endcase
    end

`ifdef ALU_EXEC_MUL_EN
    // ------------------------------------------------------------------
    // Shift-add multiplier: multiplicand walks left, multiplier walks right,
    // one partial product per MUL cycle, LSB of the multiplier first.
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      mul_cnt;
    logic [2*WIDTH-1:0] mul_sum;

    always_comb begin
        mul_sum = acc + (mplier[0] ? mcand : '0);
    end
`endif

    // ------------------------------------------------------------------
    // Control FSM with registered outputs.
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before this clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            op_q            <= '0;
            rd_q            <= '0;
            a_q             <= '0;
            b_q             <= '0;
            bus.instr_ready <= 1'b0;
            bus.readAddr1   <= '0;
            bus.readAddr2   <= '0;
            bus.writeAddr   <= '0;
            bus.writeIn     <= '0;
            bus.we          <= 1'b0;
            bus.done        <= 1'b0;
            bus.illegal     <= 1'b0;
            bus.flags       <= 4'b0000;
`ifdef ALU_EXEC_MUL_EN
            acc             <= '0;
            mcand           <= '0;
            mplier          <= '0;
            mul_cnt         <= '0;
`endif
        end else begin
            // Pulses default low and are raised only on the edge into WB.
            bus.we      <= 1'b0;
            bus.done    <= 1'b0;
            bus.illegal <= 1'b0;
            case (state)
                S_IDLE: begin
                    bus.instr_ready <= 1'b1;
                    if (bus.instr_ready && bus.instr_valid) begin
                        op_q            <= bus.op;
                        rd_q            <= bus.rd;
                        bus.readAddr1   <= bus.rs1;
                        bus.readAddr2   <= bus.rs2;
                        bus.instr_ready <= 1'b0;
                        state           <= S_READ;
                    end
                end
                S_READ: begin
                    // Operands are frozen here, so rd may alias rs1/rs2.
                    a_q   <= bus.readData1;
                    b_q   <= bus.readData2;
                    state <= S_EXEC;
`ifdef ALU_EXEC_MUL_EN
                    if (op_q == OP_MUL) begin
                        acc     <= '0;
                        mcand   <= {{WIDTH{1'b0}}, bus.readData1};
                        mplier  <= bus.readData2;
                        mul_cnt <= '0;
                        state   <= S_MUL;
                    end
`endif
                end
                S_EXEC: begin
                    bus.done <= 1'b1;
                    if (alu_legal) begin
                        bus.we        <= 1'b1;
                        bus.writeAddr <= rd_q;
                        bus.writeIn   <= alu_res;
                        bus.flags     <= {alu_res[MSB], alu_res == '0, alu_c, alu_v};
                    end else begin
                        // Illegal ops retire without a write and keep flags.
                        bus.illegal <= 1'b1;
                    end
                    state <= S_WB;
                end
`ifdef ALU_EXEC_MUL_EN
                S_MUL: begin
                    acc     <= mul_sum;
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    mul_cnt <= mul_cnt + 1'b1;
                    if (mul_cnt == CW'(WIDTH - 1)) begin
                        bus.we        <= 1'b1;
                        bus.done      <= 1'b1;
                        bus.writeAddr <= rd_q;
                        bus.writeIn   <= mul_sum[MSB:0];
                        bus.flags     <= {mul_sum[MSB], mul_sum[MSB:0] == '0,
                                          |mul_sum[2*WIDTH-1:WIDTH], 1'b0};
                        state         <= S_WB;
                    end
                end
`endif
                S_WB: begin
                    bus.instr_ready <= 1'b1;
                    state           <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_exec_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_seq
//   Self-checking bench for alu_exec_seq: reset state, a table of directed
//   vectors, random instructions against a reference model, and an abort by
//   reset in the middle of an operation. The register file is modelled here.
//   Honours ALU_EXEC_MUL_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_alu_exec_seq;
    logic clk = 1'b0;
    logic rst_n;

    alu_exec_seq_if #(.WIDTH(12), .AW(3)) ifc ();

    alu_exec_seq #(.WIDTH(12), .AW(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    // Register file seen by the DUT.
    logic [11:0] rf [8];
    assign ifc.readData1 = rf[ifc.readAddr1];
    assign ifc.readData2 = rf[ifc.readAddr2];
    always @(posedge clk) begin
        if (ifc.we === 1'b1) rf[ifc.writeAddr] <= ifc.writeIn;
    end

    // Pulse counters sampled mid-cycle.
    int we_cnt   = 0;
    int done_cnt = 0;
    always @(negedge clk) begin
        if (ifc.we === 1'b1)   we_cnt++;
        if (ifc.done === 1'b1) done_cnt++;
    end

    int total = 0;
    int bad   = 0;
    int issued = 0;
    int writes = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Reference model: instruction semantics computed with integer arithmetic.
    task automatic ref_exec(input logic [3:0] op, input logic [11:0] a, input logic [11:0] b,
                            input logic [3:0] fin, output logic [11:0] r,
                            output logic [3:0] fo, output bit ill, output int lat);
        int ua, ub, sa, sb, full, sv, q;
        bit c, v;
        ua = int'(a); ub = int'(b);
        sa = (ua >= 2048) ? ua - 4096 : ua;
        sb = (ub >= 2048) ? ub - 4096 : ub;
        c = 1'b0; v = 1'b0; ill = 1'b0; r = '0; lat = 3;
        case (int'(op))
            0: begin full = ua + ub; r = 12'(full % 4096); c = full > 4095;
                     sv = sa + sb; v = (sv > 2047) || (sv < -2048); end
            1: begin full = ua - ub; r = 12'((full + 4096) % 4096); c = ua < ub;
                     sv = sa - sb; v = (sv > 2047) || (sv < -2048); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = ~a;
            6: begin r = 12'((ua * 2) % 4096); c = ua >= 2048; end
            7: begin r = 12'(ua / 2); c = (ua % 2) == 1; end
            8: begin q = (sa < 0) ? (sa - 1) / 2 : sa / 2;
                     r = 12'((q + 4096) % 4096); c = (ua % 2) == 1; end
            9: r = a;
`ifdef ALU_EXEC_MUL_EN
            10: begin full = ua * ub; r = 12'(full % 4096); c = full >= 4096; lat = 14; end
`endif
            default: ill = 1'b1;
        endcase
        if (ill) fo = fin;
        else     fo = {r >= 12'd2048, r == 12'd0, c, v};
    endtask

    // Issue one instruction, holding instr_valid until done (so a second
    // acceptance while busy would show up as an extra done pulse).
    task automatic run_instr(input logic [3:0] op, input logic [2:0] rd,
                             input logic [2:0] rs1, input logic [2:0] rs2,
                             output int lat, output logic we_s, output logic [2:0] wa,
                             output logic [11:0] wd, output logic [3:0] fl,
                             output logic ill_s, output bit ok);
        int n;
        ok = 1'b0; lat = 99; we_s = 1'b0; wa = '0; wd = '0; fl = '0; ill_s = 1'b0;
        @(negedge clk);
        ifc.op = op; ifc.rd = rd; ifc.rs1 = rs1; ifc.rs2 = rs2;
        ifc.instr_valid = 1'b1;
        n = 0;
        while (ifc.instr_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (ifc.instr_ready !== 1'b1) begin
            ifc.instr_valid = 1'b0;
            return;
        end
        @(posedge clk);
        issued++;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (ifc.done === 1'b1) begin
                lat = k; we_s = ifc.we; wa = ifc.writeAddr; wd = ifc.writeIn;
                fl = ifc.flags; ill_s = ifc.illegal; ok = 1'b1;
                break;
            end
        end
        ifc.instr_valid = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  rd, rs1, rs2;
        bit          pre;
        logic [11:0] v1, v2;
        logic [11:0] exp_data;
        logic [3:0]  exp_flags;
        bit          exp_ill;
        int          exp_lat;
    } vec_t;

    vec_t        vecs [15];
    logic [11:0] model_rf [8];
    logic [3:0]  model_flags;

    initial begin
        int lat, elat;
        logic we_s, ill_s;
        logic [2:0] wa, rd, rs1, rs2;
        logic [11:0] wd, er;
        logic [3:0] fl, ef, op;
        bit ok, eill;
        string nm;

        //             op     rd rs1 rs2 pre  v1       v2       data     flags   ill lat
        vecs[0]  = '{4'd0,  3, 1, 2, 1, 12'h7FF, 12'h001, 12'h800, 4'b1001, 0, 3};
        vecs[1]  = '{4'd1,  1, 1, 2, 1, 12'h005, 12'h005, 12'h000, 4'b0100, 0, 3};
        vecs[2]  = '{4'd9,  4, 1, 0, 0, 12'h000, 12'h000, 12'h000, 4'b0100, 0, 3};
        vecs[3]  = '{4'd7,  5, 2, 0, 1, 12'h801, 12'h000, 12'h400, 4'b0010, 0, 3};
        vecs[4]  = '{4'd8,  6, 2, 0, 0, 12'h000, 12'h000, 12'hC00, 4'b1010, 0, 3};
        vecs[5]  = '{4'd0,  7, 3, 4, 1, 12'hFFF, 12'h001, 12'h000, 4'b0110, 0, 3};
        vecs[6]  = '{4'd1,  7, 3, 4, 1, 12'h000, 12'h001, 12'hFFF, 4'b1010, 0, 3};
        vecs[7]  = '{4'd1,  0, 3, 4, 1, 12'h800, 12'h001, 12'h7FF, 4'b0001, 0, 3};
        vecs[8]  = '{4'd2,  5, 3, 4, 1, 12'hF0F, 12'h0FF, 12'h00F, 4'b0000, 0, 3};
        vecs[9]  = '{4'd3,  5, 3, 4, 1, 12'hF00, 12'h00F, 12'hF0F, 4'b1000, 0, 3};
        vecs[10] = '{4'd4,  5, 3, 4, 1, 12'hAAA, 12'hAAA, 12'h000, 4'b0100, 0, 3};
        vecs[11] = '{4'd5,  6, 3, 4, 1, 12'h0F0, 12'h000, 12'hF0F, 4'b1000, 0, 3};
        vecs[12] = '{4'd6,  6, 3, 4, 1, 12'h801, 12'h000, 12'h002, 4'b0010, 0, 3};
        vecs[13] = '{4'd13, 2, 3, 4, 0, 12'h000, 12'h000, 12'h000, 4'b0010, 1, 3};
`ifdef ALU_EXEC_MUL_EN
        vecs[14] = '{4'd10, 7, 5, 6, 1, 12'h040, 12'h041, 12'h040, 4'b0010, 0, 14};
`else
        vecs[14] = '{4'd10, 7, 5, 6, 1, 12'h040, 12'h041, 12'h000, 4'b0010, 1, 3};
`endif

        for (int i = 0; i < 8; i++) rf[i] = 12'h000;
        ifc.instr_valid = 1'b0; ifc.op = '0; ifc.rd = '0; ifc.rs1 = '0; ifc.rs2 = '0;

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst we",        32'(ifc.we), 32'd0);
        check("rst done",      32'(ifc.done), 32'd0);
        check("rst illegal",   32'(ifc.illegal), 32'd0);
        check("rst flags",     32'(ifc.flags), 32'd0);
        check("rst writeAddr", 32'(ifc.writeAddr), 32'd0);
        check("rst writeIn",   32'(ifc.writeIn), 32'd0);
        check("rst readAddr1", 32'(ifc.readAddr1), 32'd0);
        check("rst readAddr2", 32'(ifc.readAddr2), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst ready after release", 32'(ifc.instr_ready), 32'd1);

        // ---------------- directed table ----------------
        for (int i = 0; i < 15; i++) begin
            if (vecs[i].pre) begin
                rf[vecs[i].rs1] = vecs[i].v1;
                rf[vecs[i].rs2] = vecs[i].v2;
            end
            run_instr(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
                      lat, we_s, wa, wd, fl, ill_s, ok);
            check($sformatf("vec%0d completes", i), 32'(ok), 32'd1);
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d illegal", i), 32'(ill_s), 32'(vecs[i].exp_ill));
            check($sformatf("vec%0d we", i), 32'(we_s), 32'(!vecs[i].exp_ill));
            check($sformatf("vec%0d flags", i), 32'(fl), 32'(vecs[i].exp_flags));
            if (!vecs[i].exp_ill) begin
                writes++;
                check($sformatf("vec%0d writeAddr", i), 32'(wa), 32'(vecs[i].rd));
                check($sformatf("vec%0d writeIn", i), 32'(wd), 32'(vecs[i].exp_data));
            end
        end
        model_flags = vecs[14].exp_flags;
        repeat (3) @(negedge clk);
        check("table done count", 32'(done_cnt), 32'(issued));
        check("table we count",   32'(we_cnt), 32'(writes));

        // ---------------- random vs reference model ----------------
        for (int i = 0; i < 8; i++) begin
            model_rf[i] = 12'($urandom_range(0, 4095));
            rf[i] = model_rf[i];
        end
        for (int i = 0; i < 60; i++) begin
            op  = 4'($urandom_range(0, 15));
            rd  = 3'($urandom_range(0, 7));
            rs1 = 3'($urandom_range(0, 7));
            rs2 = 3'($urandom_range(0, 7));
            ref_exec(op, model_rf[rs1], model_rf[rs2], model_flags, er, ef, eill, elat);
            run_instr(op, rd, rs1, rs2, lat, we_s, wa, wd, fl, ill_s, ok);
            nm = $sformatf("rnd%0d op%0d", i, op);
            check({nm, " latency"}, 32'(lat), 32'(elat));
            check({nm, " illegal"}, 32'(ill_s), 32'(eill));
            check({nm, " we"}, 32'(we_s), 32'(!eill));
            check({nm, " flags"}, 32'(fl), 32'(ef));
            if (!eill) begin
                writes++;
                check({nm, " writeAddr"}, 32'(wa), 32'(rd));
                check({nm, " writeIn"}, 32'(wd), 32'(er));
                model_rf[rd] = er;
            end
            model_flags = ef;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 8; i++)
            check($sformatf("rf[%0d] final", i), 32'(rf[i]), 32'(model_rf[i]));
        check("done count", 32'(done_cnt), 32'(issued));
        check("we count",   32'(we_cnt), 32'(writes));

        // ---------------- reset in the middle of an operation ----------------
        rf[1] = 12'h7FF; rf[2] = 12'h001; rf[7] = 12'h123;
        run_instr(4'd0, 3'd3, 3'd1, 3'd2, lat, we_s, wa, wd, fl, ill_s, ok);
        check("pre-abort flags", 32'(fl), 32'h9);
        @(negedge clk);
`ifdef ALU_EXEC_MUL_EN
        ifc.op = 4'd10; rf[5] = 12'h040; rf[6] = 12'h041;
        ifc.rs1 = 3'd5; ifc.rs2 = 3'd6;
`else
        ifc.op = 4'd0; ifc.rs1 = 3'd1; ifc.rs2 = 3'd2;
`endif
        ifc.rd = 3'd7; ifc.instr_valid = 1'b1;
        @(posedge clk);
        #1 ifc.instr_valid = 1'b0;
        check("abort accepted", 32'(ifc.instr_ready), 32'd0);
`ifdef ALU_EXEC_MUL_EN
        repeat (6) @(negedge clk);
`else
        repeat (2) @(negedge clk);
`endif
        writes = we_cnt;
        rst_n = 1'b0;
        #1;
        check("abort we",    32'(ifc.we), 32'd0);
        check("abort flags", 32'(ifc.flags), 32'd0);
        check("abort ready", 32'(ifc.instr_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort ready after release", 32'(ifc.instr_ready), 32'd1);
        repeat (20) @(negedge clk);
        check("abort no we pulse", 32'(we_cnt), 32'(writes));
        check("abort rf[7] kept", 32'(rf[7]), 32'h123);
        run_instr(4'd13, 3'd0, 3'd0, 3'd0, lat, we_s, wa, wd, fl, ill_s, ok);
        check("post-reset illegal", 32'(ill_s), 32'd1);
        check("post-reset flags",   32'(fl), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_exec_seq.md
Name: alu_exec_seq

Overview:
- Sequenced execute stage sitting directly downstream of the 8x12-bit two-read/one-write register file.
- Accepts one instruction at a time over a valid/ready handshake and drives both regfile read addresses.
- Captures the two operands, computes a 12-bit ALU result (optionally a multi-cycle shift-add multiply), and writes it back through the regfile write port as a single-cycle we pulse.
- Maintains a registered status-flag word.

Parameters:
- WIDTH, 12, datapath width; must match regfile data width.
- AW, 3, register address width (8 registers).

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- instr_valid  input  1  instruction present.
- instr_ready  output  1  block can accept an instruction (high only in IDLE).
- op  input  4  opcode.
- rd  input  AW  destination register.
- rs1  input  AW  source register 1.
- rs2  input  AW  source register 2.
- readAddr1  output  AW  to regfile readAddr1.
- readAddr2  output  AW  to regfile readAddr2.
- readData1  input  WIDTH  from regfile readOut1 (combinational).
- readData2  input  WIDTH  from regfile readOut2 (combinational).
- writeAddr  output  AW  to regfile writeAddr.
- writeIn  output  WIDTH  to regfile writeIn.
- we  output  1  to regfile we; one-cycle pulse.
- done  output  1  one-cycle pulse, coincident with we or with an illegal-op retire.
- flags  output  4  {N,Z,C,V}, registered.
- illegal  output  1  one-cycle pulse with done when the opcode is unsupported.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - we, done and illegal are 0; flags = 4'b0000; writeAddr, writeIn, readAddr1 and readAddr2 are 0.
  - instr_ready goes high after reset is released.
  - Reset mid-operation aborts with no write.
- States: IDLE, READ, EXEC, MUL, WB.
- IDLE:
  - instr_ready=1.
  - On instr_valid=1 at a clock edge: latch op, rd, rs1, rs2; go to READ.
- READ:
  - readAddr1=rs1, readAddr2=rs2 (registered, held).
  - At end of cycle capture readData1/2 into operand registers A and B.
  - Next state is MUL if op=MUL and the feature is enabled, else EXEC.
- EXEC: compute result and flags into registers; go to WB.
- WB:
  - we=1, writeAddr=rd, writeIn=result, done=1 for exactly one cycle; flags update on the same edge.
  - Return to IDLE.
  - An illegal op skips the write: we=0, done=1, illegal=1, flags unchanged.
- Latency:
  - Accept edge, then READ, then EXEC, then WB: we is high in the 3rd cycle after acceptance.
  - MUL: READ, then 12 MUL cycles, then WB.
- Back-to-back: instr_ready returns high in the cycle after WB; no overlap.
- Because operands are captured in READ, rd may equal rs1 or rs2 without hazard.
- Opcodes (result / C / V):
  - 0 ADD: A+B; C = carry out; V = signed overflow.
  - 1 SUB: A-B; C = borrow (A<B unsigned); V = signed overflow.
  - 2 AND, 3 OR, 4 XOR: C=0, V=0.
  - 5 NOT: ~A; C=0, V=0.
  - 6 SHL: A<<1; C = A[11]; V=0.
  - 7 SHR: A>>1 logical; C = A[0]; V=0.
  - 8 SRA: arithmetic right shift by 1; C = A[0]; V=0.
  - 9 MOV: A; C=0, V=0.
  - 10 MUL: see Optional Feature.
  - 11-15: illegal.
- All ops: N = result[11]; Z = (result==0). All arithmetic is modulo 2^12.
- instr_valid while busy is ignored; the source must hold it until instr_ready.

Optional Feature:
- Macro: ALU_EXEC_MUL_EN.
- Defined:
  - op 10 is an unsigned shift-add multiply, one bit of B per MUL cycle, LSB first, 12 cycles, with a 24-bit accumulator.
  - result = product[11:0]; C = |product[23:12]; V=0.
  - Reset during MUL aborts with no write.
- Undefined:
  - No MUL state or accumulator is built.
  - op 10 is illegal: done plus illegal pulse after READ, then EXEC, then WB timing; no write; flags unchanged.

Test Plan:
- Reset mid-MUL (or mid-EXEC) -> we never pulses; flags=0000; instr_ready=1 one cycle after release.
- r1=0x7FF, r2=0x001, ADD rd=3 -> we in 3rd cycle after accept, writeAddr=3, writeIn=0x800, flags N=1 Z=0 C=0 V=1.
- r1=0x005, r2=0x005, SUB rd=1 (rd==rs1) -> writeIn=0x000, Z=1 C=0; a following MOV r4<-r1 writes 0x000.
- r2=0x801, SHR rs1=2 then SRA rs1=2 -> 0x400 with C=1; then 0xC00 with C=1.
- MUL r5=0x040 * r6=0x041 (feature on) -> we 14 cycles after accept, writeIn=0x040, C=1; with the feature off -> illegal=1, we=0, flags unchanged.
- op=13 -> done and illegal pulse, no we; instr_valid held during busy is not accepted twice (exactly one done per handshake).
